// File: rtl/iq_demod_pkg.sv
// Shared types, mixer LUT and the round/saturate helper for the IQ downconverter.
// Optional feature macro: IQ_DEMOD_LPF_EN (see iq_demod_top).
package iq_demod_pkg;

  localparam int W_IN   = 5;
  localparam int W_OUT  = 5;
  localparam int W_COEF = 6;

  localparam int OUT_MAX = 2 ** (W_OUT - 1) - 1;
  localparam int OUT_MIN = -(2 ** (W_OUT - 1));

  typedef logic signed [W_IN-1:0]   sample_t;
  typedef logic signed [W_OUT-1:0]  out_t;
  typedef logic signed [W_COEF-1:0] coef_t;
  typedef logic signed [11:0]       acc_t;
  // FIR sum of up to four products needs two guard bits over acc_t.
  typedef logic signed [13:0]       acc_w_t;
  typedef logic [2:0]               phase_t;

  localparam phase_t PHASE_LAST = 3'd4;

  // exp(-j*2*pi*p/5) scaled by 29/32, Q0.5
  localparam coef_t COS_LUT [5] = '{6'sd29, 6'sd9, -6'sd23, -6'sd23, 6'sd9};
  localparam coef_t SIN_LUT [5] = '{6'sd0, 6'sd28, 6'sd17, -6'sd17, -6'sd28};

  // Round half up by 2^shift, then clamp to the output range.
  function automatic out_t sat_round_w(input acc_w_t a, input int unsigned shift);
    logic signed [14:0] t;
    logic signed [14:0] r;
    t = {a[13], a} + (15'sd1 <<< (shift - 1));
    r = t >>> shift;
    if (r > 15'(OUT_MAX)) begin
      sat_round_w = out_t'(OUT_MAX);
    end else if (r < 15'(OUT_MIN)) begin
      sat_round_w = out_t'(OUT_MIN);
    end else begin
      sat_round_w = r[W_OUT-1:0];
    end
  endfunction

  function automatic out_t sat_round(input acc_t a, input int unsigned shift);
    sat_round = sat_round_w({{2{a[11]}}, a}, shift);
  endfunction

endpackage

// File: rtl/iq_demod_mixer.sv
// Registered complex multiply of one IF sample by the (C,S) LUT pair of its phase.
// Products are held between valid samples.
module iq_mixer
  import iq_demod_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  sample_t i_i,
  input  sample_t q_i,
  input  phase_t  phase_i,
  output logic    valid_o,
  output acc_t    mi_o,
  output acc_t    mq_o
);

  coef_t c_lut;
  coef_t s_lut;
  logic  valid_d, valid_q;
  acc_t  mi_d, mi_q;
  acc_t  mq_d, mq_q;

  // (I + jQ) * (C - jS): mI = I*C + Q*S, mQ = Q*C - I*S
  always_comb begin
    c_lut   = COS_LUT[phase_i];
    s_lut   = SIN_LUT[phase_i];
    valid_d = valid_i;
    mi_d    = mi_q;
    mq_d    = mq_q;
    if (valid_i) begin
      mi_d = acc_t'(i_i) * acc_t'(c_lut) + acc_t'(q_i) * acc_t'(s_lut);
      mq_d = acc_t'(q_i) * acc_t'(c_lut) - acc_t'(i_i) * acc_t'(s_lut);
    end
  end

  // Product and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mi_q    <= '0;
      mq_q    <= '0;
    end else begin
      valid_q <= valid_d;
      mi_q    <= mi_d;
      mq_q    <= mq_d;
    end
  end

  assign valid_o = valid_q;
  assign mi_o    = mi_q;
  assign mq_o    = mq_q;

endmodule

// File: rtl/iq_demod_top.sv
// Low-IF (fs/5) to baseband complex downconverter.
// Pipeline: input capture + phase -> mixer -> [optional FIR] -> round/saturate.
// Define IQ_DEMOD_LPF_EN to insert a [1 2 1]/4 image-reject FIR (latency 3 instead of 2).
// Handshake: ADC_rdy_i is a one-cycle strobe qualifying I_IF/Q_IF; demod_iq_valid is a
// one-cycle strobe marking a new I_BB/Q_BB, which hold their value in between.
module iq_demod_top
  import iq_demod_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    ADC_rdy_i,
  input  sample_t I_IF,
  input  sample_t Q_IF,
  output logic    demod_iq_valid,
  output out_t    I_BB,
  output out_t    Q_BB
);

  phase_t  phase_d, phase_q;
  logic    s0_valid_d, s0_valid_q;
  sample_t s0_i_d, s0_i_q;
  sample_t s0_q_d, s0_q_q;
  phase_t  s0_ph_d, s0_ph_q;

  logic    mix_valid;
  acc_t    mix_i;
  acc_t    mix_q;

  logic    src_valid;
  out_t    src_i;
  out_t    src_q;

  logic    out_valid_d, out_valid_q;
  out_t    i_bb_d, i_bb_q;
  out_t    q_bb_d, q_bb_q;

  // Capture a sample with its phase on each strobe; phase steps 0..4 and wraps
  always_comb begin
    phase_d    = phase_q;
    s0_valid_d = ADC_rdy_i;
    s0_i_d     = s0_i_q;
    s0_q_d     = s0_q_q;
    s0_ph_d    = s0_ph_q;
    if (ADC_rdy_i) begin
      s0_i_d  = I_IF;
      s0_q_d  = Q_IF;
      s0_ph_d = phase_q;
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 3'd1;
    end
  end

  // Input stage and phase counter registers
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      phase_q    <= '0;
      s0_valid_q <= 1'b0;
      s0_i_q     <= '0;
      s0_q_q     <= '0;
      s0_ph_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      s0_valid_q <= s0_valid_d;
      s0_i_q     <= s0_i_d;
      s0_q_q     <= s0_q_d;
      s0_ph_q    <= s0_ph_d;
    end
  end

  iq_mixer u_mixer (
    .clk     (clk),
    .rst     (resetn),
    .valid_i (s0_valid_q),
    .i_i     (s0_i_q),
    .q_i     (s0_q_q),
    .phase_i (s0_ph_q),
    .valid_o (mix_valid),
    .mi_o    (mix_i),
    .mq_o    (mix_q)
  );

`ifdef IQ_DEMOD_LPF_EN
  acc_t   fir_d1_i_d, fir_d1_i_q, fir_d2_i_d, fir_d2_i_q;
  acc_t   fir_d1_q_d, fir_d1_q_q, fir_d2_q_d, fir_d2_q_q;
  acc_w_t fir_sum_i_d, fir_sum_i_q;
  acc_w_t fir_sum_q_d, fir_sum_q_q;
  logic   fir_valid_d, fir_valid_q;

  // [1 2 1] FIR advanced once per mixer sample; the /4 is folded into the final shift
  always_comb begin
    fir_valid_d = mix_valid;
    fir_d1_i_d  = fir_d1_i_q;
    fir_d2_i_d  = fir_d2_i_q;
    fir_d1_q_d  = fir_d1_q_q;
    fir_d2_q_d  = fir_d2_q_q;
    fir_sum_i_d = fir_sum_i_q;
    fir_sum_q_d = fir_sum_q_q;
    if (mix_valid) begin
      fir_d1_i_d  = mix_i;
      fir_d2_i_d  = fir_d1_i_q;
      fir_d1_q_d  = mix_q;
      fir_d2_q_d  = fir_d1_q_q;
      fir_sum_i_d = acc_w_t'(mix_i) + (acc_w_t'(fir_d1_i_q) <<< 1) + acc_w_t'(fir_d2_i_q);
      fir_sum_q_d = acc_w_t'(mix_q) + (acc_w_t'(fir_d1_q_q) <<< 1) + acc_w_t'(fir_d2_q_q);
    end
  end

  // FIR delay line and sum registers
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      fir_valid_q <= 1'b0;
      fir_d1_i_q  <= '0;
      fir_d2_i_q  <= '0;
      fir_d1_q_q  <= '0;
      fir_d2_q_q  <= '0;
      fir_sum_i_q <= '0;
      fir_sum_q_q <= '0;
    end else begin
      fir_valid_q <= fir_valid_d;
      fir_d1_i_q  <= fir_d1_i_d;
      fir_d2_i_q  <= fir_d2_i_d;
      fir_d1_q_q  <= fir_d1_q_d;
      fir_d2_q_q  <= fir_d2_q_d;
      fir_sum_i_q <= fir_sum_i_d;
      fir_sum_q_q <= fir_sum_q_d;
    end
  end

  assign src_valid = fir_valid_q;
  assign src_i     = sat_round_w(fir_sum_i_q, 7);
  assign src_q     = sat_round_w(fir_sum_q_q, 7);
`else
  assign src_valid = mix_valid;
  assign src_i     = sat_round(mix_i, 5);
  assign src_q     = sat_round(mix_q, 5);
`endif

  // Output registers update only on a new sample and hold otherwise
  always_comb begin
    out_valid_d = src_valid;
    i_bb_d      = i_bb_q;
    q_bb_d      = q_bb_q;
    if (src_valid) begin
      i_bb_d = src_i;
      q_bb_d = src_q;
    end
  end

  // Output stage registers
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      out_valid_q <= 1'b0;
      i_bb_q      <= '0;
      q_bb_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      i_bb_q      <= i_bb_d;
      q_bb_q      <= q_bb_d;
    end
  end

  assign demod_iq_valid = out_valid_q;
  assign I_BB           = i_bb_q;
  assign Q_BB           = q_bb_q;

endmodule

// File: tb/tb_iq_demod_top.sv
// Bench for iq_demod_top: randomized and directed samples, scoreboard queue of
// expected (arrival cycle, I_BB, Q_BB), monitor popping on every valid strobe.
`timescale 1ns/1ps
module tb_iq_demod_top;

`ifdef IQ_DEMOD_LPF_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              ADC_rdy_i = 1'b0;
  logic signed [4:0] I_IF = '0;
  logic signed [4:0] Q_IF = '0;
  logic              demod_iq_valid;
  logic signed [4:0] I_BB;
  logic signed [4:0] Q_BB;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // {arrival cycle[31:0], I[4:0], Q[4:0]}
  logic [41:0] exp_q[$];
  logic signed [4:0] last_i = '0;
  logic signed [4:0] last_q = '0;

  // reference model state
  int cos_t[5] = '{29, 9, -23, -23, 9};
  int sin_t[5] = '{0, 28, 17, -17, -28};
  int m_ph = 0;
  int hi1 = 0, hi2 = 0, hq1 = 0, hq2 = 0;

  // expected I_BB/Q_BB for test 2 (I=10, Q=0), phase 0..4
  int tab_i[5] = '{9, 3, -7, -7, 3};
  int tab_q[5] = '{0, -9, -5, 5, 9};

  iq_demod_top dut (
    .clk            (clk),
    .resetn         (resetn),
    .ADC_rdy_i      (ADC_rdy_i),
    .I_IF           (I_IF),
    .Q_IF           (Q_IF),
    .demod_iq_valid (demod_iq_valid),
    .I_BB           (I_BB),
    .Q_BB           (Q_BB)
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) floor_div = a / b;
    else        floor_div = -((-a + b - 1) / b);
  endfunction

  function automatic int clamp(input int v);
    if (v > 15)       clamp = 15;
    else if (v < -16) clamp = -16;
    else              clamp = v;
  endfunction

  task automatic model_reset();
    m_ph = 0; hi1 = 0; hi2 = 0; hq1 = 0; hq2 = 0;
  endtask

  // drive one sample (called at a negedge, returns one negedge later with strobe still high)
  task automatic send(input int i, input int q, input bit use_c, input int ci, input int cq);
    int p, mi, mq, ei, eq;
    p    = m_ph;
    m_ph = (m_ph + 1) % 5;
    mi   = i * cos_t[p] + q * sin_t[p];
    mq   = q * cos_t[p] - i * sin_t[p];
`ifdef IQ_DEMOD_LPF_EN
    ei  = clamp(floor_div(mi + 2 * hi1 + hi2 + 64, 128));
    eq  = clamp(floor_div(mq + 2 * hq1 + hq2 + 64, 128));
    hi2 = hi1; hi1 = mi; hq2 = hq1; hq1 = mq;
`else
    ei = clamp(floor_div(mi + 16, 32));
    eq = clamp(floor_div(mq + 16, 32));
    if (use_c) begin
      ei = ci;
      eq = cq;
    end
`endif
    ADC_rdy_i = 1'b1;
    I_IF      = 5'(i);
    Q_IF      = 5'(q);
    exp_q.push_back({32'(cyc + 1 + LAT), 5'(ei), 5'(eq)});
    @(negedge clk);
  endtask

  // drop the strobe, scribble on the data inputs, wait n cycles
  task automatic idle(input int n);
    ADC_rdy_i = 1'b0;
    I_IF      = 5'($urandom_range(0, 31));
    Q_IF      = 5'($urandom_range(0, 31));
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rand();
    send($urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, 1'b0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (demod_iq_valid !== 1'b0 || I_BB !== 5'sd0 || Q_BB !== 5'sd0) begin
      n_fail++;
      $display("FAIL %s got valid=%b I=%0d Q=%0d required valid=0 I=0 Q=0",
               name, demod_iq_valid, I_BB, Q_BB);
    end
  endtask

  // reset pulse between strobes; aborts anything in flight
  task automatic reset_mid();
    @(negedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
    last_i = '0;
    last_q = '0;
    model_reset();
    #1;
    check_zero("mid_reset_outputs");
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [41:0]       e;
    int                ecyc;
    logic signed [4:0] ei, eq;
    if (!resetn) begin
      if (demod_iq_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid cyc=%0d got I=%0d Q=%0d required no valid",
                   cyc, I_BB, Q_BB);
        end else begin
          e    = exp_q.pop_front();
          ecyc = int'(e[41:10]);
          ei   = e[9:5];
          eq   = e[4:0];
          if (ecyc != cyc || I_BB !== ei || Q_BB !== eq) begin
            n_fail++;
            $display("FAIL sample got I=%0d Q=%0d at cyc=%0d required I=%0d Q=%0d at cyc=%0d",
                     I_BB, Q_BB, cyc, ei, eq, ecyc);
          end
          last_i = ei;
          last_q = eq;
        end
      end else begin
        n_checks++;
        if (I_BB !== last_i || Q_BB !== last_q) begin
          n_fail++;
          $display("FAIL hold cyc=%0d got I=%0d Q=%0d required I=%0d Q=%0d",
                   cyc, I_BB, Q_BB, last_i, last_q);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][41:10]) <= cyc) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_valid cyc=%0d got valid=0 required valid at cyc=%0d",
                   cyc, int'(e[41:10]));
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    // reset for 100 ns
    #1 resetn = 1'b1;
    @(negedge clk);
    repeat (5) begin
      check_zero("reset_outputs");
      @(negedge clk);
    end
    #1 resetn = 1'b0;
    @(negedge clk);

    // phase sweep and rounding, I=10 Q=0, strobe every 5 clk
    for (int k = 0; k < 10; k++) begin
      send(10, 0, 1'b1, tab_i[k % 5], tab_q[k % 5]);
      idle(4);
    end

    // saturation at phase 1
    send(3, -2, 1'b0, 0, 0); idle(4);
    send(15, 15, 1'b1, 15, -9); idle(4);
    for (int k = 0; k < 4; k++) begin
      send_rand(); idle(4);
    end
    send(-16, -16, 1'b1, -16, 10); idle(4);

    // random samples with random spacing, including back-to-back strobes
    for (int k = 0; k < 60; k++) begin
      send_rand();
      idle($urandom_range(0, 5));
    end
    idle(8);

    // reset with a sample in flight; next sample restarts at phase 0
    send(7, -3, 1'b0, 0, 0);
    idle(0);
    reset_mid();
    idle(6);
    send(10, 0, 1'b1, 9, 0); idle(4);
    send(10, 0, 1'b1, 3, -9); idle(4);

    for (int k = 0; k < 40; k++) begin
      send_rand();
      idle($urandom_range(0, 4));
    end

`ifdef IQ_DEMOD_LPF_EN
    // constant tone through the filter
    for (int k = 0; k < 20; k++) begin
      send(10, 0, 1'b0, 0, 0); idle(4);
    end
`endif

    idle(0);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout got %0d pending samples required 0", exp_q.size());
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
